// File: rtl/sic_pkg.sv
// Shared types and constants for the SIC word-to-byte memory controller.
package sic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } mem_state_t;

    localparam int BYTES_PER_WORD = 3;

endpackage

// File: rtl/sic_mem_ctrl.sv
// SIC CPU word port to byte-wide SRAM bridge: one 24-bit access becomes three big-endian byte accesses.
// Optional bounds checking of the word base address is enabled with `define SIC_MEM_BOUNDS_CHECK_EN.
module sic_mem_ctrl
    import sic_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 15,
    parameter int DATA_WIDTH    = 24,
    parameter int BYTE_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_cpu_req,
    input  logic                     i_cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0]    i_cpu_wdata,
    output logic [DATA_WIDTH-1:0]    o_cpu_rdata,
    output logic                     o_cpu_ack,
    output logic                     o_cpu_busy,
    output logic                     o_cpu_err,
    output logic                     o_mem_en,
    output logic                     o_mem_we,
    output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
    output logic [BYTE_WIDTH-1:0]    o_mem_wdata,
    input  logic [BYTE_WIDTH-1:0]    i_mem_rdata
);

    if (DATA_WIDTH != BYTES_PER_WORD * BYTE_WIDTH) begin : g_width_check
        $error("sic_mem_ctrl: DATA_WIDTH must equal BYTES_PER_WORD*BYTE_WIDTH");
    end

    // A read needs one extra count to capture the last byte, which arrives a cycle after its enable.
    localparam logic [1:0] READ_LAST_CNT  = 2'(BYTES_PER_WORD);
    localparam logic [1:0] WRITE_LAST_CNT = 2'(BYTES_PER_WORD - 1);

    mem_state_t                        r_state;
    mem_state_t                        w_nextState;
    logic [1:0]                        r_cnt;
    logic [1:0]                        w_nextCnt;
    logic [ADDRESS_WIDTH-1:0]          r_base;
    logic [DATA_WIDTH-1:0]             r_wdata;
    logic [DATA_WIDTH-BYTE_WIDTH-1:0]  r_asm;
    logic [DATA_WIDTH-1:0]             r_rdata;
    logic [ADDRESS_WIDTH-1:0]          w_byteAddr;
    logic                              w_outOfRange;
    logic                              w_errFlag;

`ifdef SIC_MEM_BOUNDS_CHECK_EN
    localparam logic [ADDRESS_WIDTH-1:0] LAST_VALID_BASE = ADDRESS_WIDTH'(2**ADDRESS_WIDTH - 3);
    logic r_err;

    assign w_outOfRange = (i_cpu_addr > LAST_VALID_BASE);
    assign w_errFlag    = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == IDLE && i_cpu_req) begin
            r_err <= w_outOfRange;
        end
    end
`else
    assign w_outOfRange = 1'b0;
    assign w_errFlag    = 1'b0;
`endif

    // Byte address wraps modulo 2^ADDRESS_WIDTH through the truncating add.
    assign w_byteAddr  = r_base + ADDRESS_WIDTH'(r_cnt);
    assign o_cpu_rdata = r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // Memory-side outputs decode only registered state so the CPU port has no combinational path to the SRAM.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        o_cpu_ack   = 1'b0;
        o_cpu_err   = 1'b0;
        o_cpu_busy  = 1'b1;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (r_state)
            IDLE: begin
                o_cpu_busy = 1'b0;
                if (i_cpu_req) begin
                    w_nextCnt = 2'd0;
                    if (w_outOfRange) begin
                        w_nextState = DONE;
                    end else if (i_cpu_we) begin
                        w_nextState = WRITE;
                    end else begin
                        w_nextState = READ;
                    end
                end
            end
            READ: begin
                if (r_cnt != READ_LAST_CNT) begin
                    o_mem_en   = 1'b1;
                    o_mem_addr = w_byteAddr;
                    w_nextCnt  = r_cnt + 2'd1;
                end else begin
                    w_nextState = DONE;
                    w_nextCnt   = 2'd0;
                end
            end
            WRITE: begin
                o_mem_en   = 1'b1;
                o_mem_we   = 1'b1;
                o_mem_addr = w_byteAddr;
                case (r_cnt)
                    2'd0:    o_mem_wdata = r_wdata[DATA_WIDTH-1 -: BYTE_WIDTH];
                    2'd1:    o_mem_wdata = r_wdata[DATA_WIDTH-1-BYTE_WIDTH -: BYTE_WIDTH];
                    default: o_mem_wdata = r_wdata[BYTE_WIDTH-1:0];
                endcase
                if (r_cnt == WRITE_LAST_CNT) begin
                    w_nextState = DONE;
                    w_nextCnt   = 2'd0;
                end else begin
                    w_nextCnt = r_cnt + 2'd1;
                end
            end
            DONE: begin
                o_cpu_ack   = 1'b1;
                o_cpu_err   = w_errFlag;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = 2'd0;
            end
        endcase
    end

    // Read bytes shift in MSB first; the final byte is merged straight into the result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base  <= '0;
            r_wdata <= '0;
            r_asm   <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_cpu_req) begin
                        r_base  <= i_cpu_addr;
                        r_wdata <= i_cpu_wdata;
                    end
                end
                READ: begin
                    if (r_cnt == READ_LAST_CNT) begin
                        r_rdata <= {r_asm, i_mem_rdata};
                    end else if (r_cnt != 2'd0) begin
                        r_asm <= {r_asm[DATA_WIDTH-2*BYTE_WIDTH-1:0], i_mem_rdata};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sic_mem_ctrl.sv
// Self-checking bench for sic_mem_ctrl: table-driven word transfers against a behavioural SRAM,
// plus held-request, wrap-around and mid-transfer reset sequences.
module tb_sic_mem_ctrl;

    localparam int AW = 15;
    localparam int DW = 24;
    localparam int BW = 8;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] expRdata;
        bit            expErr;
    } vec_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cpu_req;
    logic          i_cpu_we;
    logic [AW-1:0] i_cpu_addr;
    logic [DW-1:0] i_cpu_wdata;
    logic [DW-1:0] o_cpu_rdata;
    logic          o_cpu_ack;
    logic          o_cpu_busy;
    logic          o_cpu_err;
    logic          o_mem_en;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [BW-1:0] o_mem_wdata;
    logic [BW-1:0] memRdata;

    logic [BW-1:0] sram [0:(1<<AW)-1];
    logic [DW-1:0] expQ [$];
    acc_t          accQ [$];
    logic [DW-1:0] prevRdata;
    vec_t          vecs [10];
    int            checks = 0;
    int            errors = 0;

    sic_mem_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_cpu_req   (i_cpu_req),
        .i_cpu_we    (i_cpu_we),
        .i_cpu_addr  (i_cpu_addr),
        .i_cpu_wdata (i_cpu_wdata),
        .o_cpu_rdata (o_cpu_rdata),
        .o_cpu_ack   (o_cpu_ack),
        .o_cpu_busy  (o_cpu_busy),
        .o_cpu_err   (o_cpu_err),
        .o_mem_en    (o_mem_en),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (memRdata)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: synchronous write, read data one cycle after the enable.
    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_we) sram[o_mem_addr] = o_mem_wdata;
            else          memRdata <= sram[o_mem_addr];
        end
    end

    always @(negedge clk) begin
        if (o_mem_en) accQ.push_back('{o_mem_we, o_mem_addr, o_mem_wdata});
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int            cycles;
        int            nAcc;
        int            expLat;
        bit            gotAck;
        logic [DW-1:0] expWord;
        logic [DW-1:0] shifted;
        logic [AW-1:0] expAddr;
        accQ.delete();
        @(negedge clk);
        i_cpu_req   = 1'b1;
        i_cpu_we    = v.we;
        i_cpu_addr  = v.addr;
        i_cpu_wdata = v.wdata;
        if (!v.we && !v.expErr) expQ.push_back(v.expRdata);
        expLat = v.expErr ? 1 : (v.we ? 4 : 5);
        cycles = 0;
        gotAck = 1'b0;
        while (!gotAck && cycles < 20) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (cycles == 1) checkOutput("busy_after_accept", o_cpu_busy, 1);
            if (o_cpu_ack) gotAck = 1'b1;
            else           checkOutput("rdata_held", o_cpu_rdata, prevRdata);
        end
        if (!gotAck) begin
            checkOutput("ack_timeout", 0, 1);
        end else begin
            checkOutput("latency", cycles, expLat);
            checkOutput("err", o_cpu_err, v.expErr);
            if (v.expErr) begin
                checkOutput("rdata_unchanged", o_cpu_rdata, prevRdata);
            end else if (!v.we) begin
                if (expQ.size() == 0) begin
                    checkOutput("scoreboard_empty", 0, 1);
                end else begin
                    expWord = expQ.pop_front();
                    checkOutput("rdata", o_cpu_rdata, expWord);
                    prevRdata = expWord;
                end
            end
        end
        i_cpu_req = 1'b0;
        nAcc = v.expErr ? 0 : 3;
        checkOutput("acc_count", accQ.size(), nAcc);
        for (int i = 0; i < accQ.size() && i < nAcc; i++) begin
            expAddr = v.addr + AW'(i);
            checkOutput("acc_addr", accQ[i].addr, expAddr);
            checkOutput("acc_we", accQ[i].we, v.we);
            if (v.we) begin
                shifted = v.wdata >> (BW * (2 - i));
                checkOutput("acc_wdata", accQ[i].wdata, shifted[BW-1:0]);
            end
        end
        @(negedge clk);
        checkOutput("ack_one_cycle", o_cpu_ack, 0);
        checkOutput("idle_not_busy", o_cpu_busy, 0);
    endtask

    task automatic heldReqSeq();
        int            cyc;
        int            lastAck;
        int            nAck;
        logic [DW-1:0] expWord;
        accQ.delete();
        @(negedge clk);
        i_cpu_req   = 1'b1;
        i_cpu_we    = 1'b1;
        i_cpu_addr  = 15'h0300;
        i_cpu_wdata = 24'h010203;
        cyc     = 0;
        lastAck = 0;
        nAck    = 0;
        while (nAck < 4 && cyc < 60) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (o_cpu_ack) begin
                checkOutput("held_no_en_in_done", o_mem_en, 0);
                if (nAck == 0) checkOutput("held_first_latency", cyc, 4);
                else           checkOutput("held_gap", cyc - lastAck, (nAck % 2 == 1) ? 6 : 5);
                if (nAck % 2 == 1) begin
                    if (expQ.size() == 0) begin
                        checkOutput("held_scoreboard_empty", 0, 1);
                    end else begin
                        expWord = expQ.pop_front();
                        checkOutput("held_rdata", o_cpu_rdata, expWord);
                        prevRdata = expWord;
                    end
                end
                lastAck = cyc;
                nAck++;
                case (nAck)
                    1: begin i_cpu_we = 1'b0; expQ.push_back(24'h010203); end
                    2: begin i_cpu_we = 1'b1; i_cpu_wdata = 24'h0D0E0F; end
                    3: begin i_cpu_we = 1'b0; expQ.push_back(24'h0D0E0F); end
                    default: i_cpu_req = 1'b0;
                endcase
            end
        end
        if (nAck < 4) checkOutput("held_timeout", nAck, 4);
        i_cpu_req = 1'b0;
        checkOutput("held_acc_count", accQ.size(), 12);
        @(negedge clk);
        checkOutput("held_idle", o_cpu_busy, 0);
    endtask

    task automatic resetDuringWrite();
        sram[15'h0400] = 8'hEE;
        sram[15'h0401] = 8'hEE;
        sram[15'h0402] = 8'hEE;
        @(negedge clk);
        i_cpu_req   = 1'b1;
        i_cpu_we    = 1'b1;
        i_cpu_addr  = 15'h0400;
        i_cpu_wdata = 24'h778899;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("pre_rst_en", o_mem_en, 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_async_en", o_mem_en, 0);
        checkOutput("rst_async_we", o_mem_we, 0);
        checkOutput("rst_async_busy", o_cpu_busy, 0);
        i_cpu_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_no_ack", o_cpu_ack, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ack", o_cpu_ack, 0);
        checkOutput("post_rst_busy", o_cpu_busy, 0);
        checkOutput("rst_byte0_written", sram[15'h0400], 8'h77);
        checkOutput("rst_byte2_not_written", sram[15'h0402], 8'hEE);
        checkOutput("post_rst_rdata", o_cpu_rdata, 0);
        prevRdata = '0;
    endtask

    initial begin
        rst         = 1'b1;
        i_cpu_req   = 1'b0;
        i_cpu_we    = 1'b0;
        i_cpu_addr  = '0;
        i_cpu_wdata = '0;
        prevRdata   = '0;
        for (int i = 0; i < (1 << AW); i++) sram[i] = 8'h00;
        sram[15'h0010] = 8'h12;
        sram[15'h0011] = 8'h34;
        sram[15'h0012] = 8'h56;
        sram[15'h7FFD] = 8'hB6;
        sram[15'h7FFE] = 8'hC7;
        sram[15'h7FFF] = 8'hD8;
        sram[15'h0000] = 8'hE9;
        sram[15'h0001] = 8'h55;
        sram[15'h0002] = 8'h44;

        vecs[0] = '{1'b1, 15'h0100, 24'hABCDEF, 24'h000000, 1'b0};
        vecs[1] = '{1'b0, 15'h0010, 24'h000000, 24'h123456, 1'b0};
        vecs[2] = '{1'b0, 15'h0100, 24'h000000, 24'hABCDEF, 1'b0};
        vecs[3] = '{1'b1, 15'h0200, 24'h5AA53C, 24'h000000, 1'b0};
        vecs[4] = '{1'b0, 15'h0200, 24'h000000, 24'h5AA53C, 1'b0};
`ifdef SIC_MEM_BOUNDS_CHECK_EN
        vecs[5] = '{1'b1, 15'h7FFF, 24'h112233, 24'h000000, 1'b1};
        vecs[6] = '{1'b0, 15'h7FFE, 24'h000000, 24'h000000, 1'b1};
        vecs[7] = '{1'b0, 15'h7FFD, 24'h000000, 24'hB6C7D8, 1'b0};
        vecs[8] = '{1'b0, 15'h0000, 24'h000000, 24'hE95544, 1'b0};
        vecs[9] = '{1'b1, 15'h7FFE, 24'h0A0B0C, 24'h000000, 1'b1};
`else
        vecs[5] = '{1'b1, 15'h7FFF, 24'h112233, 24'h000000, 1'b0};
        vecs[6] = '{1'b0, 15'h7FFE, 24'h000000, 24'hC71122, 1'b0};
        vecs[7] = '{1'b0, 15'h7FFD, 24'h000000, 24'hB6C711, 1'b0};
        vecs[8] = '{1'b0, 15'h0000, 24'h000000, 24'h223344, 1'b0};
        vecs[9] = '{1'b1, 15'h7FFE, 24'h0A0B0C, 24'h000000, 1'b0};
`endif

        repeat (2) @(negedge clk);
        checkOutput("reset_rdata", o_cpu_rdata, 0);
        checkOutput("reset_ack", o_cpu_ack, 0);
        checkOutput("reset_busy", o_cpu_busy, 0);
        checkOutput("reset_err", o_cpu_err, 0);
        checkOutput("reset_mem_en", o_mem_en, 0);
        checkOutput("reset_mem_we", o_mem_we, 0);
        checkOutput("reset_mem_addr", o_mem_addr, 0);
        checkOutput("reset_mem_wdata", o_mem_wdata, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_ignores_no_req", o_cpu_busy, 0);

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

        heldReqSeq();
        resetDuringWrite();

        applyStimulus('{1'b0, 15'h0010, 24'h000000, 24'h123456, 1'b0});

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
